prefix_scan_engine: RTL and testbench
=====================================

Name: prefix_scan_engine

Overview:
- Parametrised in-place scan accelerator. Reads LEN words from a single-port array memory starting at a base index, combines each word into a running accumulator, and writes the running value back to the same address.
- Successor to the fixed 64-bit prefix-sum kernel. Adds configurable width/depth, four scan modes, saturation/overflow reporting, a length input and an explicit busy status.
- Sits between the host and one array RAM; the host regains the RAM port while the engine is idle.

Parameters:
DATA_W, 64, signed element/accumulator width in bits
ADDR_W, 10, array address width; depth = 2**ADDR_W
LEN_W, 11, width of length input; must be ≥ ADDR_W+1 so a full-depth scan is expressible

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
r_enable  in  1  start pulse; sampled only in IDLE
init_i  in  ADDR_W  base index of scan
init_acc  in  DATA_W  signed initial accumulator value
len  in  LEN_W  number of elements to process
mode  in  2  0=wrapping sum, 1=saturating signed sum, 2=running max, 3=running min
w_enable  out  1  one-cycle done pulse
busy  out  1  high from the cycle after accepted start until the w_enable cycle inclusive
result  out  DATA_W  final accumulator value, held until next accepted start
ovf  out  1  sticky: a mode-1 saturation or mode-0 signed wrap occurred during the last scan
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, registered, valid the cycle after the address

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - w_enable=0, busy=0, result=0, ovf=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A reset mid-scan aborts the scan. No further writes occur and no w_enable is issued. RAM contents already written remain.
- FSM states:
  - IDLE: r_enable=1 latches init_i, init_acc, len and mode. It also clears ovf and counter k=0.
    - len=0 goes to DONE.
    - Otherwise goes to RD.
  - RD: mem_addr = (base+k) mod 2**ADDR_W, mem_we=0. Goes to WR.
  - WR: acc' = f(acc, mem_rdata). mem_we=1, mem_addr unchanged, mem_wdata=acc'. acc<=acc', k<=k+1.
    - If k+1==len, goes to DONE.
    - Otherwise goes to RD.
  - DONE: result<=acc, w_enable=1 for exactly this cycle. Goes to IDLE.
- Latency: an accepted start at cycle T gives w_enable at T+2*len+1.
  - len=0 gives w_enable at T+1 with result=init_acc.
- Combine function f, all signed DATA_W:
  - mode 0: a+b truncated; sets ovf on signed overflow.
  - mode 1: a+b clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1]; sets ovf when clamped.
  - mode 2: max(a,b).
  - mode 3: min(a,b).
  - Modes 2/3 never set ovf.
- Address wrap: base+k wraps modulo depth.
  - len > depth is legal; later elements re-read already-written words.
  - Behaviour is defined by the sequential RD/WR order.
- r_enable while busy is ignored; latched parameters are not disturbed.
- r_enable in the DONE cycle is ignored; a start is accepted in IDLE only.
- In IDLE: mem_we=0 and mem_addr holds its last value. The host owns the RAM through its own mux, keyed on busy=0.
- Inputs init_i/init_acc/len/mode may change freely after the start cycle.

Decomposition:
- Package scan_pkg holds:
  - typedef enum scan_state_e {IDLE, RD, WR, DONE}
  - typedef enum scan_mode_e {SUM_WRAP, SUM_SAT, MAX, MIN}
  - Saturation limit constant functions parameterised on DATA_W.
- One combinational sub-module, scan_combine, holds f() and the overflow detect (inputs a, b, mode; outputs y, ovf). The FSM, counter and RAM interface stay in prefix_scan_engine.

Test Plan:
- Mode 0: preload 1000 random values in [0, 2**31-1], base=0, len=1000, init_acc=0 -> each addr i holds the prefix sum through i; w_enable at T+2001; ovf=0.
- Mode 1: DATA_W=8, data {100,100,-50}, init_acc=0, len=3 -> RAM {100,127,77}, result=77, ovf=1. Mode 0 on the same data -> {100,-56,-106}, ovf=1.
- Modes 2/3: data {3,-7,9,2}, init_acc=0 -> max gives {3,3,9,9}, min gives {0,-7,-7,-7}, ovf=0.
- Wrap and zero-length:
  - ADDR_W=10, base=1022, len=4 -> writes land at 1022, 1023, 0, 1 in that order.
  - len=0, init_acc=42 -> w_enable one cycle after start, result=42, no mem_we.
- Control robustness:
  - r_enable pulsed mid-scan -> ignored; result is unchanged from the uninterrupted run.
  - rst_n low mid-scan -> outputs reset immediately, no w_enable.
  - A new scan after reset completes correctly.

Source files
------------

// File: rtl/prefix_scan_engine_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and helpers for the prefix scan engine:
//   scan_state_e : engine FSM states
//   scan_mode_e  : combine function selector (matches the 2-bit mode port)
//   sat_max_f / sat_min_f : signed saturation limits for a given data width
// -----------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } scan_state_e;

    typedef enum logic [1:0] {
        SUM_WRAP = 2'd0,
        SUM_SAT  = 2'd1,
        MAX      = 2'd2,
        MIN      = 2'd3
    } scan_mode_e;

    // Wide enough for any practical DATA_W; callers truncate to their width.
    localparam int SAT_LIMIT_W = 128;

    // Largest signed value of a data_w-bit word: 0111...1
    function automatic logic [SAT_LIMIT_W-1:0] sat_max_f(input int data_w);
        sat_max_f = (SAT_LIMIT_W'(1) << (data_w - 1)) - SAT_LIMIT_W'(1);
    endfunction

    // Smallest signed value; its low data_w bits are 1000...0
    function automatic logic [SAT_LIMIT_W-1:0] sat_min_f(input int data_w);
        sat_min_f = ~sat_max_f(data_w);
    endfunction

endpackage

// File: rtl/prefix_scan_engine_combine.sv
// -----------------------------------------------------------------------------
// scan_combine
// Purely combinational combine step y = f(a, b) for the scan engine.
//   a    : running accumulator (signed)
//   b    : element read from memory (signed)
//   mode : SUM_WRAP / SUM_SAT / MAX / MIN
//   y    : combined value
//   ovf  : signed wrap (SUM_WRAP) or clamp (SUM_SAT); never set for MAX/MIN
// -----------------------------------------------------------------------------
module scan_combine
    import scan_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  scan_mode_e               mode,
    output logic signed [DATA_W-1:0] y,
    output logic                     ovf
);

    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max_f(DATA_W));
    localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min_f(DATA_W));

    logic signed [DATA_W-1:0] sum_s;
    logic                     wrap_s;

    // Truncated sum and signed-overflow detect (same-sign operands, sign flip)
    always_comb begin
        sum_s  = a + b;
        wrap_s = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
    end

    // Mode select; on saturation the operand sign tells which rail was crossed
    always_comb begin
        y   = sum_s;
        ovf = 1'b0;
        case (mode)
            SUM_WRAP: begin
                y   = sum_s;
                ovf = wrap_s;
            end
            SUM_SAT: begin
                if (wrap_s) begin
                    y = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    y = sum_s;
                end
                ovf = wrap_s;
            end
            MAX: begin
                y   = (a > b) ? a : b;
                ovf = 1'b0;
            end
            MIN: begin
                y   = (a < b) ? a : b;
                ovf = 1'b0;
            end
            default: begin
                y   = sum_s;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/prefix_scan_engine.sv
// -----------------------------------------------------------------------------
// prefix_scan_engine
// In-place scan over a single-port array RAM: for k = 0..len-1 reads word
// (base+k) mod depth, combines it into the accumulator, writes the running
// value back to the same address. One RD and one WR cycle per element.
//   clk, rst_n       : clock, async active-low reset
//   r_enable         : start pulse, only honoured in IDLE
//   init_i/init_acc/len/mode : scan parameters, latched at start
//   w_enable         : one-cycle done pulse
//   busy             : engine owns the RAM port
//   result, ovf      : final accumulator and sticky overflow of last scan
//   mem_we/mem_addr/mem_wdata/mem_rdata : RAM port (1-cycle read latency)
// -----------------------------------------------------------------------------
module prefix_scan_engine
    import scan_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     r_enable,
    input  logic [ADDR_W-1:0]        init_i,
    input  logic signed [DATA_W-1:0] init_acc,
    input  logic [LEN_W-1:0]         len,
    input  logic [1:0]               mode,
    output logic                     w_enable,
    output logic                     busy,
    output logic signed [DATA_W-1:0] result,
    output logic                     ovf,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic signed [DATA_W-1:0] mem_wdata,
    input  logic signed [DATA_W-1:0] mem_rdata
);

    scan_state_e              state_r;
    scan_state_e              state_s;
    scan_mode_e               mode_r;
    logic [ADDR_W-1:0]        base_r;
    logic [LEN_W-1:0]         len_r;
    logic [LEN_W-1:0]         k_r;
    logic signed [DATA_W-1:0] acc_r;
    logic                     ovf_r;
    logic signed [DATA_W-1:0] result_r;
    logic                     w_enable_r;
    logic                     busy_r;
    logic                     mem_we_r;
    logic [ADDR_W-1:0]        mem_addr_r;

    logic signed [DATA_W-1:0] y_s;
    logic                     comb_ovf_s;
    logic                     last_s;
    logic                     busy_s;
    logic                     w_enable_s;
    logic                     mem_we_s;
    logic [ADDR_W-1:0]        next_addr_s;
    logic [ADDR_W-1:0]        addr_s;
    logic signed [DATA_W-1:0] final_acc_s;
    logic signed [DATA_W-1:0] wdata_s;

    scan_combine #(
        .DATA_W (DATA_W)
    ) u_combine (
        .a    (acc_r),
        .b    (mem_rdata),
        .mode (mode_r),
        .y    (y_s),
        .ovf  (comb_ovf_s)
    );

    // k counts completed elements, so the WR of element len-1 is the last one
    assign last_s = ((k_r + LEN_W'(1)) == len_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (r_enable) begin
                    state_s = (len == {LEN_W{1'b0}}) ? DONE : RD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD:      state_s = WR;
            WR: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RD;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode: values the output registers take on the next edge
    always_comb begin
        busy_s     = (state_s != IDLE);
        w_enable_s = (state_s == DONE);
        mem_we_s   = (state_s == WR);

        // Address of the next RD: base itself from IDLE, base+k+1 after a WR
        if (state_r == IDLE) begin
            next_addr_s = init_i;
        end else begin
            next_addr_s = base_r + ADDR_W'(k_r + LEN_W'(1));
        end

        // WR reuses the RD address; IDLE/DONE keep the last one
        if (state_s == RD) begin
            addr_s = next_addr_s;
        end else begin
            addr_s = mem_addr_r;
        end

        // Zero-length scans finish straight from IDLE with init_acc
        case (state_r)
            IDLE:    final_acc_s = init_acc;
            WR:      final_acc_s = y_s;
            default: final_acc_s = acc_r;
        endcase

        // Write data depends on read data that is only valid in the WR cycle
        if (state_r == WR) begin
            wdata_s = y_s;
        end else begin
            wdata_s = {DATA_W{1'b0}};
        end
    end

    // Scan parameters, accumulator, element counter and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= {ADDR_W{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            k_r    <= {LEN_W{1'b0}};
            acc_r  <= {DATA_W{1'b0}};
            mode_r <= SUM_WRAP;
            ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (r_enable) begin
                        base_r <= init_i;
                        len_r  <= len;
                        acc_r  <= init_acc;
                        mode_r <= scan_mode_e'(mode);
                        k_r    <= {LEN_W{1'b0}};
                        ovf_r  <= 1'b0;
                    end
                end
                WR: begin
                    acc_r <= y_s;
                    k_r   <= k_r + LEN_W'(1);
                    if (comb_ovf_s) begin
                        ovf_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status and RAM control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            w_enable_r <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            result_r   <= {DATA_W{1'b0}};
        end else begin
            busy_r     <= busy_s;
            w_enable_r <= w_enable_s;
            mem_we_r   <= mem_we_s;
            mem_addr_r <= addr_s;
            if (w_enable_s) begin
                result_r <= final_acc_s;
            end
        end
    end

    assign busy      = busy_r;
    assign w_enable  = w_enable_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = wdata_s;
    assign result    = result_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_prefix_scan_engine.sv
// -----------------------------------------------------------------------------
// tb_prefix_scan_engine
// Scoreboard bench: each start pushes the predicted RAM writes and the predicted
// completion (result, ovf, cycle) into queues; a negedge monitor pops and
// compares whenever the engine writes or pulses w_enable. Predictions come from
// a plain-integer model of the scan over a shadow copy of the RAM.
// -----------------------------------------------------------------------------
module tb_prefix_scan_engine;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int DEPTH = 1 << AW;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int res; bit ovf; longint cyc; } dn_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 r_enable = 1'b0;
    logic [AW-1:0]        init_i = '0;
    logic signed [DW-1:0] init_acc = '0;
    logic [LW-1:0]        len = '0;
    logic [1:0]           mode = '0;
    logic                 w_enable, busy, ovf, mem_we;
    logic signed [DW-1:0] result, mem_wdata, mem_rdata;
    logic [AW-1:0]        mem_addr;

    logic                 host_we = 1'b0;
    logic [AW-1:0]        host_addr = '0;
    logic [DW-1:0]        host_wdata = '0;
    logic [DW-1:0]        ram [DEPTH];

    int     mdl [DEPTH];
    wr_t    wq [$];
    dn_t    dq [$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     done_cnt = 0;
    int     n_issued = 0;
    int     last_res;
    bit     last_ovf;

    always #5 clk = ~clk;

    prefix_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_i(init_i),
        .init_acc(init_acc), .len(len), .mode(mode), .w_enable(w_enable),
        .busy(busy), .result(result), .ovf(ovf), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Array RAM with registered read; host port active while the engine is idle
    always @(posedge clk) begin
        if (busy) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end else if (host_we) begin
            ram[host_addr] <= host_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Edge counter for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx(input logic [DW-1:0] v);
        sx = int'($signed(v));
    endfunction

    // Reference combine in plain integer arithmetic
    function automatic void f_ref(input int md, input int a, input int b,
                                  output int y, output bit o);
        int s, hi, lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        s  = a + b;
        o  = 1'b0;
        case (md)
            0: begin
                o = (s > hi) || (s < lo);
                y = (s > hi) ? s - (1 << DW) : ((s < lo) ? s + (1 << DW) : s);
            end
            1: begin
                o = (s > hi) || (s < lo);
                y = (s > hi) ? hi : ((s < lo) ? lo : s);
            end
            2: y = (a > b) ? a : b;
            default: y = (a < b) ? a : b;
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
    endtask

    // Monitor: pops expectations whenever the DUT writes or completes
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    fail_evt("unexpected_write");
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", int'(mem_addr), w.addr);
                    chk("wr_data", sx(mem_wdata), w.data);
                end
            end
            if (w_enable) begin
                if (dq.size() == 0) begin
                    fail_evt("unexpected_done");
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    chk("result", sx(result), d.res);
                    chk("ovf", longint'(ovf), longint'(d.ovf));
                    chk("latency", cyc, d.cyc);
                    chk("busy_at_done", longint'(busy), 1);
                end
                done_cnt++;
            end
        end
    end

    task automatic host_wr(input int a, input int d);
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = AW'(a);
        host_wdata = DW'(d);
        @(posedge clk);
        #1 host_we = 1'b0;
        mdl[a] = sx(DW'(d));
    endtask

    // Drive a start pulse in IDLE and push the model's predictions
    task automatic issue(input int base, input int n, input int acc0, input int md);
        int acc, y, a;
        bit o, oo;
        @(negedge clk);
        r_enable = 1'b1;
        init_i   = AW'(base);
        init_acc = DW'(acc0);
        len      = LW'(n);
        mode     = 2'(md);
        acc = sx(DW'(acc0));
        o   = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = (base + k) % DEPTH;
            f_ref(md, acc, mdl[a], y, oo);
            acc    = y;
            o      = o | oo;
            mdl[a] = acc;
            wq.push_back('{a, acc});
        end
        dq.push_back('{acc, o, cyc + 1 + 2 * n});
        last_res = acc;
        last_ovf = o;
        n_issued++;
        @(posedge clk);
        #1 r_enable = 1'b0;
        init_i   = AW'($urandom);
        init_acc = DW'($urandom);
        len      = LW'($urandom);
        mode     = 2'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (done_cnt < n_issued && t < bound) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < n_issued) fail_evt("done_timeout");
        chk("writes_drained", wq.size(), 0);
    endtask

    task automatic run_scan(input int base, input int n, input int acc0, input int md);
        issue(base, n, acc0, md);
        wait_done(2 * n + 10);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_w_enable"}, longint'(w_enable), 0);
        chk({tag, "_mem_we"}, longint'(mem_we), 0);
        chk({tag, "_mem_addr"}, longint'(mem_addr), 0);
        chk({tag, "_result"}, longint'(result), 0);
        chk({tag, "_ovf"}, longint'(ovf), 0);
        chk({tag, "_mem_wdata"}, longint'(mem_wdata), 0);
    endtask

    initial begin
        #1 chk_reset_outputs("rst");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) host_wr(i, int'($urandom));

        // Saturating then wrapping sum on {100, 100, -50}
        host_wr(0, 100); host_wr(1, 100); host_wr(2, -50);
        run_scan(0, 3, 0, 1);
        chk("sat_result", sx(result), 77);
        chk("sat_ovf", longint'(ovf), 1);
        chk("sat_ram1", sx(ram[1]), 127);
        host_wr(0, 100); host_wr(1, 100); host_wr(2, -50);
        run_scan(0, 3, 0, 0);
        chk("wrap_result", sx(result), -106);
        chk("wrap_ram1", sx(ram[1]), -56);
        chk("wrap_ovf", longint'(ovf), 1);

        // Running max / min on {3, -7, 9, 2}
        host_wr(10, 3); host_wr(11, -7); host_wr(12, 9); host_wr(13, 2);
        run_scan(10, 4, 0, 2);
        chk("max_result", sx(result), 9);
        chk("max_ovf", longint'(ovf), 0);
        host_wr(10, 3); host_wr(11, -7); host_wr(12, 9); host_wr(13, 2);
        run_scan(10, 4, 0, 3);
        chk("min_result", sx(result), -7);
        chk("min_ram10", sx(ram[10]), 0);

        // Address wrap at top of the array, then zero length
        run_scan(1022, 4, 5, 0);
        run_scan(500, 0, 42, 1);
        chk("len0_result", sx(result), 42);

        // Start request during the done cycle must be dropped
        issue(300, 2, 1, 2);
        for (int t = 0; t < 20 && !w_enable; t++) @(negedge clk);
        r_enable = 1'b1;
        len      = LW'(5);
        @(posedge clk);
        #1 r_enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("done_start_ignored", longint'(busy), 0);
        end

        // Start request mid-scan must not disturb the running scan
        issue(100, 20, 7, 1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        r_enable = 1'b1;
        init_i   = AW'(700);
        init_acc = DW'(-3);
        len      = LW'(3);
        mode     = 2'd3;
        @(posedge clk);
        #1 r_enable = 1'b0;
        wait_done(60);
        chk("midstart_result", sx(result), last_res);
        chk("midstart_ovf", longint'(ovf), longint'(last_ovf));

        // Reset mid-scan: outputs clear at once, no completion afterwards
        issue(200, 30, 0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        wq.delete();
        dq.delete();
        n_issued = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = sx(ram[i]);
        repeat (70) @(negedge clk);
        chk("abort_no_done", done_cnt, n_issued);

        // Fresh scan after reset, then randomized scans
        run_scan(200, 30, 0, 0);
        for (int it = 0; it < 12; it++) begin
            int nw;
            nw = int'($urandom_range(0, 4));
            for (int j = 0; j < nw; j++) host_wr(int'($urandom_range(0, DEPTH - 1)), int'($urandom));
            run_scan(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 60)),
                     int'($urandom), int'($urandom_range(0, 3)));
        end
        run_scan(0, 1000, 0, int'($urandom_range(0, 3)));
        run_scan(int'($urandom_range(0, DEPTH - 1)), 1100, int'($urandom), int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
